// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state encoding and default sizes for the register store sequencer
package alu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_STORE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_BIT_COUNT = 8;
    localparam int DEF_REG_COUNT = 4;
    localparam int STORE_CNT_W   = 4;

endpackage

// File: rtl/store_decoder.sv
// rtl/store_decoder.sv - enable-gated address to one-hot store line decoder
module store_decoder
    import alu_pkg::*;
#(
    parameter int ADDR_W    = 2,
    parameter int REG_COUNT = DEF_REG_COUNT
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [REG_COUNT-1:0] onehot
);

    // Only indices that exist get a line; an out-of-range address decodes to all-zero.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (en && (32'(addr) == i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_store_sequencer.sv
// rtl/register_store_sequencer.sv - latch-safe write sequencer; REGISTER_STORE_VERIFY_EN adds readback check
module register_store_sequencer
    import alu_pkg::*;
#(
    parameter int BIT_COUNT    = DEF_BIT_COUNT,
    parameter int REG_COUNT    = DEF_REG_COUNT,
    parameter int ADDR_W       = 2,
    parameter int STORE_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [BIT_COUNT-1:0]           req_data,
    output logic [BIT_COUNT-1:0]           reg_data,
    output logic [REG_COUNT-1:0]           reg_store,
    output logic                           busy,
    output logic                           done,
    output logic                           addr_err
`ifdef REGISTER_STORE_VERIFY_EN
    ,
    input  logic [REG_COUNT*BIT_COUNT-1:0] reg_memory,
    output logic                           verify_err
`endif
);

    state_t                 state;
    logic [ADDR_W-1:0]      cap_addr;
    logic [STORE_CNT_W-1:0] cnt;
    logic [REG_COUNT-1:0]   dec_onehot;
    logic                   addr_oob;

    assign addr_oob = (32'(cap_addr) >= REG_COUNT);

    // The decoder only produces a strobe pattern while SETUP is loading the STORE strobe.
    store_decoder #(
        .ADDR_W    (ADDR_W),
        .REG_COUNT (REG_COUNT)
    ) u_store_decoder (
        .en     (state == ST_SETUP),
        .addr   (cap_addr),
        .onehot (dec_onehot)
    );

`ifdef REGISTER_STORE_VERIFY_EN
    logic readback_bad;

    // Compare the addressed register's output against the data still driven on the bus.
    always_comb begin
        readback_bad = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if ((32'(cap_addr) == i) && (reg_memory[i*BIT_COUNT +: BIT_COUNT] != reg_data)) begin
                readback_bad = 1'b1;
            end
        end
    end
`else
    // Without the readback option there is no register feedback and no compare.
`endif

    // Sequencer FSM; every output is loaded on the edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_err  <= 1'b0;
            reg_data  <= '0;
            reg_store <= '0;
            cap_addr  <= '0;
            cnt       <= '0;
`ifdef REGISTER_STORE_VERIFY_EN
            verify_err <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_addr  <= req_addr;
                        reg_data  <= req_data;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    reg_store <= dec_onehot;
                    cnt       <= STORE_CNT_W'(STORE_CYCLES - 1);
                    state     <= ST_STORE;
                end
                ST_STORE: begin
                    if (cnt == '0) begin
                        reg_store <= '0;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    done     <= 1'b1;
                    addr_err <= addr_oob;
`ifdef REGISTER_STORE_VERIFY_EN
                    verify_err <= !addr_oob && readback_bad;
`endif
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    addr_err  <= 1'b0;
`ifdef REGISTER_STORE_VERIFY_EN
                    verify_err <= 1'b0;
`endif
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
